pwm_deadtime: RTL

PWM_DEADTIME -- requirements
Module: pwm_deadtime

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_deadtime_if.sv | 28 ++
 rtl/cdc_sync.sv | 24 ++
 rtl/dffr.sv | 17 +
 rtl/pwm_dt_chnl.sv | 115 +++++++++++
 rtl/pwm_deadtime.sv | 71 +++++++
 6 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the dead-time PWM block.
package pwm_pkg;

  localparam int CH_NUM_DEF   = 4;
  localparam int DT_WIDTH_DEF = 8;

  // Per-channel drive state; OFF must encode as zero so reset lands there.
  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_LOW   = 3'd1,
    ST_DT_LH = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DT_HL = 3'd4
  } chnl_state_e;

endpackage

// File: rtl/pwm_deadtime_if.sv
// Control/status bundle between the PWM counter stage and the dead-time block.
interface pwm_deadtime_if
  import pwm_pkg::*;
#(
  parameter int CH_NUM   = CH_NUM_DEF,
  parameter int DT_WIDTH = DT_WIDTH_DEF
);

  logic [CH_NUM-1:0]   pwm_i;
  logic                en_i;
  logic [DT_WIDTH-1:0] dt_i;
  logic                flt_i;
  logic                flt_clr_i;
  logic [CH_NUM-1:0]   pwm_h_o;
  logic [CH_NUM-1:0]   pwm_l_o;
  logic                flt_o;

  modport master (
    output pwm_i, en_i, dt_i, flt_i, flt_clr_i,
    input  pwm_h_o, pwm_l_o, flt_o
  );

  modport slave (
    input  pwm_i, en_i, dt_i, flt_i, flt_clr_i,
    output pwm_h_o, pwm_l_o, flt_o
  );

endinterface

// File: rtl/cdc_sync.sv
// Two-flop level synchroniser, one independent chain per bit.
module cdc_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dffr.sv
// Plain D flip-flop bank with asynchronous active-low clear.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage with async clear to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/pwm_dt_chnl.sv
// One PWM channel: Moore FSM with dead-time down-counter and registered
// high/low drive decoded from the next state.
module pwm_dt_chnl
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_in,
  input  logic                force_off,
  input  logic [DT_WIDTH-1:0] dt,
  output logic                pwm_h,
  output logic                pwm_l
);

  chnl_state_e         state;
  chnl_state_e         state_nxt;
  logic [2:0]          state_q;
  logic [DT_WIDTH-1:0] cnt;
  logic [DT_WIDTH-1:0] cnt_nxt;
  logic [DT_WIDTH-1:0] dt_load;
  logic                dt_zero;
  logic [1:0]          drv_nxt;
  logic [1:0]          drv_q;

  assign dt_zero = (dt == '0);
  // Window length is D cycles: load D-1, leave when the counter reads zero.
  assign dt_load = dt - DT_WIDTH'(1);
  assign state   = chnl_state_e'(state_q);

  dffr #(.W(3)) u_state (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (state_nxt),
    .q     (state_q)
  );

  dffr #(.W(DT_WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cnt_nxt),
    .q     (cnt)
  );

  // Drive flops hold the decode of the state being entered, so they always
  // equal a decode of the current state and can never both be set.
  assign drv_nxt = {state_nxt == ST_HIGH, state_nxt == ST_LOW};

  dffr #(.W(2)) u_drv (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (drv_nxt),
    .q     (drv_q)
  );

  assign pwm_h = drv_q[1];
  assign pwm_l = drv_q[0];

  // Next-state and counter logic; dt is only looked at when a window opens.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (force_off) begin
      state_nxt = ST_OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          if (dt_zero) begin
            state_nxt = s_in ? ST_HIGH : ST_LOW;
          end else begin
            state_nxt = s_in ? ST_DT_LH : ST_DT_HL;
            cnt_nxt   = dt_load;
          end
        end
        ST_LOW: begin
          if (s_in) begin
            if (dt_zero) begin
              state_nxt = ST_HIGH;
            end else begin
              state_nxt = ST_DT_LH;
              cnt_nxt   = dt_load;
            end
          end
        end
        ST_HIGH: begin
          if (!s_in) begin
            if (dt_zero) begin
              state_nxt = ST_LOW;
            end else begin
              state_nxt = ST_DT_HL;
              cnt_nxt   = dt_load;
            end
          end
        end
        ST_DT_LH: begin
          if (!s_in)          state_nxt = ST_LOW;
          else if (cnt == '0) state_nxt = ST_HIGH;
          else                cnt_nxt   = cnt - DT_WIDTH'(1);
        end
        ST_DT_HL: begin
          if (s_in)           state_nxt = ST_HIGH;
          else if (cnt == '0) state_nxt = ST_LOW;
          else                cnt_nxt   = cnt - DT_WIDTH'(1);
        end
        default: begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_deadtime.sv
// Multi-channel complementary PWM driver with dead-time insertion,
// sticky fault brake and global enable.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int CH_NUM   = CH_NUM_DEF,
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  pwm_deadtime_if.slave        bus
);

  logic [CH_NUM-1:0] s_in;
  logic [CH_NUM-1:0] pwm_h;
  logic [CH_NUM-1:0] pwm_l;
  logic              flt_q;
  logic              flt_nxt;
  logic [1:0]        arm_q;
  logic              force_off;

  cdc_sync #(.W(CH_NUM)) u_sync (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .d     (bus.pwm_i),
    .q     (s_in)
  );

  // Sticky fault: a request sets it, a clear only wins when no request is present.
  always_comb begin
    flt_nxt = flt_q;
    if (bus.flt_i)          flt_nxt = 1'b1;
    else if (bus.flt_clr_i) flt_nxt = 1'b0;
  end

  dffr #(.W(1)) u_flt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .d     (flt_nxt),
    .q     (flt_q)
  );

  // After reset the synchroniser outputs are not yet valid; hold every channel
  // in OFF until they are, so the first window starts from a real input level
  // and the first drive lands 3+D cycles after release.
  dffr #(.W(2)) u_arm (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .d     ({arm_q[0], 1'b1}),
    .q     (arm_q)
  );

  assign force_off = bus.flt_i | flt_q | ~bus.en_i | ~arm_q[1];

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    pwm_dt_chnl #(.DT_WIDTH(DT_WIDTH)) u_chnl (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .s_in      (s_in[g]),
      .force_off (force_off),
      .dt        (bus.dt_i),
      .pwm_h     (pwm_h[g]),
      .pwm_l     (pwm_l[g])
    );
  end

  assign bus.pwm_h_o = pwm_h;
  assign bus.pwm_l_o = pwm_l;
  assign bus.flt_o   = flt_q;

endmodule
